counter_updown_load: RTL
========================

COUNTER_UPDOWN_LOAD -- requirements
Module: counter_updown_load

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (1 or more).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, giving the count ceiling (legal range 1 to 2**WIDTH-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-007 The block SHALL have port d, input, WIDTH bits: load value.
REQ-008 The block SHALL have port up, input, 1 bit: direction, 1 = up and 0 = down.
REQ-009 The block SHALL have port sat, input, 1 bit: boundary mode, 1 = saturate and 0 = wrap.
REQ-010 The block SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky, registered boundary-event flag.

Function
REQ-014 The block SHALL sample all inputs on the rising edge of clk, with q and ovf updating at that edge (one-cycle latency); there SHALL be no other pipelining.
REQ-015 Priority per edge SHALL be: load first, then en, then hold.
REQ-016 When load=1, the block SHALL set q to d, independent of en, up and sat.
REQ-017 When load=1 and d > MAX_VAL, the block SHALL set q to MAX_VAL (clamp).
REQ-018 A load SHALL never set ovf.
REQ-019 When load=0, en=1, up=1 and q < MAX_VAL, the block SHALL set q to q+1.
REQ-020 When load=0, en=1, up=1 and q == MAX_VAL, the block SHALL hold q if sat=1 and set q to 0 if sat=0; in both cases it SHALL set ovf.
REQ-021 When load=0, en=1, up=0 and q > 0, the block SHALL set q to q-1.
REQ-022 When load=0, en=1, up=0 and q == 0, the block SHALL hold q if sat=1 and set q to MAX_VAL if sat=0; in both cases it SHALL set ovf.
REQ-023 When load=0 and en=0, the block SHALL hold q and ovf unchanged, apart from ovf_clr.
REQ-024 The block SHALL never drive q above MAX_VAL, and arithmetic SHALL not rely on natural 2**WIDTH rollover when MAX_VAL < 2**WIDTH-1.
REQ-025 The block SHALL drive tc = 1 when (up=1 and q == MAX_VAL) or (up=0 and q == 0), and 0 otherwise; tc SHALL follow changes in up within the same cycle.
REQ-026 The block SHALL clear ovf on an edge where ovf_clr=1.
REQ-027 On an edge where ovf_clr=1 and a boundary event both occur, set SHALL win and ovf SHALL read 1.
REQ-028 Changes to up or sat SHALL take effect at the next edge; a direction change SHALL not itself cause a count or set ovf.

Reset
REQ-029 On rst_n=0, the block SHALL immediately force q=0 and ovf=0, asynchronously and without waiting for clk.
REQ-030 During reset, tc SHALL equal NOT up, consistent with q=0.
REQ-031 Edges while rst_n=0 SHALL be ignored.
REQ-032 The first state change after release SHALL occur on the first rising edge with rst_n=1.
REQ-033 Asserting rst_n mid-count or during a load SHALL abort the operation with no residual state.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-034 Up-count with wrap: reset, then up=1, sat=0, en=1 for 11 edges -> q = 1..9, 0, 1; tc=1 only while q=9; ovf=1 from the edge where q goes 9 to 0.
REQ-035 Saturation in both directions: load d=8, sat=1, up=1, 3 enabled edges -> q = 9, 9, 9 and ovf=1; then up=0 with q forced to 0, 2 enabled edges -> q stays 0 and tc=1.
REQ-036 Load priority and clamp: with en=1, load=1, d=4'b1001 -> q=9 next edge with ovf unchanged; with load=1, d=4'b1111 -> q=9.
REQ-037 Down wrap: q=0, up=0, sat=0, en=1 -> q=9 next edge and ovf=1; with ovf_clr=1 in the same cycle as a further wrap event -> ovf stays 1; ovf_clr=1 with no event -> ovf=0.
REQ-038 Asynchronous reset: assert rst_n=0 between clock edges while q=6 -> q=0 and ovf=0 before the next edge; hold en=1 through 2 edges in reset -> q remains 0.
REQ-039 Full-range default: WIDTH=4, MAX_VAL=15, up=1, sat=0, 17 enabled edges -> q wraps 15 to 0 once and ovf=1.

Source files
------------

// File: rtl/counter_updown_load.sv
// counter_updown_load: loadable up/down counter with wrap/saturate and sticky overflow
module counter_updown_load #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic             at_max, at_zero, boundary;
  logic [WIDTH-1:0] q_next;
  // Boundary detection and next count; compares against MAX so no reliance on 2**WIDTH rollover
  always_comb begin
    at_max   = q == MAX;
    at_zero  = q == '0;
    tc       = up ? at_max : at_zero;
    boundary = !load && en && tc;
    q_next   = load ? (d > MAX ? MAX : d) :
               !en  ? q :
               up   ? (at_max  ? (sat ? q : '0)  : q + 1'b1) :
                      (at_zero ? (sat ? q : MAX) : q - 1'b1);
  end
  // Count register and sticky overflow; a boundary event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= boundary | (ovf & !ovf_clr);
    end
  end
endmodule
